// File: rtl/capi_put_cmd_split.sv
// Put-command splitter: forwards a request's data beats and cuts the stream
// into PSL put commands at page and (optionally) max-transfer boundaries.
// Command descriptors are queued in a small FIFO for the command issue logic.
module capi_put_cmd_split #(
    parameter int EA_WIDTH   = 64,
    parameter int TAG_WIDTH  = 5,
    parameter int AUX_WIDTH  = 24,
    parameter int BEAT_BYTES = 16,
    parameter int PAGE_BYTES = 4096,
    parameter int MAX_XFER   = 512,
    parameter int CMD_DEPTH  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_req_v,
    output logic                            o_req_r,
    input  logic [EA_WIDTH-1:0]             i_req_ea,
    input  logic [TAG_WIDTH-1:0]            i_req_tag,
    input  logic [AUX_WIDTH-1:0]            i_req_aux,
    input  logic                            i_split_en,
    input  logic                            i_data_v,
    output logic                            o_data_r,
    input  logic [$clog2(BEAT_BYTES)-1:0]   i_data_cnt,
    input  logic                            i_data_e,
    output logic                            o_data_v,
    input  logic                            i_data_r,
    output logic                            o_data_first,
    output logic                            o_data_last,
    output logic                            o_cmd_v,
    input  logic                            i_cmd_r,
    output logic [EA_WIDTH-1:0]             o_cmd_ea,
    output logic [$clog2(PAGE_BYTES):0]     o_cmd_tsize,
    output logic [TAG_WIDTH-1:0]            o_cmd_tag,
    output logic [AUX_WIDTH-1:0]            o_cmd_aux,
    output logic                            o_cmd_final,
    output logic                            o_busy,
    output logic                            o_err
);
    localparam int BB_W = $clog2(BEAT_BYTES);
    localparam int PG_W = $clog2(PAGE_BYTES);
    localparam int MX_W = $clog2(MAX_XFER);
    localparam int TS_W = PG_W + 1;
    localparam int AW   = $clog2(CMD_DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    typedef struct packed {
        logic [EA_WIDTH-1:0]  ea;
        logic [TS_W-1:0]      tsize;
        logic [TAG_WIDTH-1:0] tag;
        logic [AUX_WIDTH-1:0] aux;
        logic                 last;
    } cmd_t;

    state_t                state, state_nxt;
    logic [EA_WIDTH-1:0]   seg_ea;
    logic [TS_W-1:0]       seg_len;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [AUX_WIDTH-1:0]  aux_q;
    logic                  split_q;
    logic                  first_pend;

    logic [TS_W-1:0]       page_rem, xfer_rem, limit, beat_bytes, new_len;
    logic                  req_acc, beat_acc, close, push, pop;
    logic                  fifo_full, fifo_empty;
    logic [AW:0]           wr_ptr, rd_ptr;
    cmd_t                  mem [CMD_DEPTH];
    cmd_t                  head;
    logic [EA_WIDTH-1:0]   ea_aligned;

    // Bytes left before the next hard (page) or optional (max-xfer) boundary
    assign page_rem   = TS_W'(PAGE_BYTES) - TS_W'(seg_ea[PG_W-1:0]);
    assign xfer_rem   = TS_W'(MAX_XFER) - TS_W'(seg_ea[MX_W-1:0]);
    assign limit      = (split_q && (xfer_rem < page_rem)) ? xfer_rem : page_rem;
    assign beat_bytes = (i_data_cnt == '0) ? TS_W'(BEAT_BYTES) : TS_W'(i_data_cnt);
    assign new_len    = seg_len + beat_bytes;
    assign close      = i_data_e | (new_len >= limit);

    assign ea_aligned = {i_req_ea[EA_WIDTH-1:BB_W], {BB_W{1'b0}}};
    assign req_acc    = i_req_v & o_req_r;
    assign beat_acc   = i_data_v & o_data_r;
    assign push       = beat_acc & close;
    assign pop        = i_cmd_r & ~fifo_empty;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: stream from request accept until the beat marked end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_req_v)             state_nxt = STREAM;
            STREAM:  if (beat_acc && i_data_e) state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; a full FIFO blocks beats so no close can be lost
    always_comb begin
        o_req_r  = (state == IDLE);
        o_data_r = (state == STREAM) & (~o_data_v | i_data_r) & ~fifo_full;
    end

    // Request latch and running segment (start address, accumulated length)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_ea     <= '0;
            seg_len    <= '0;
            tag_q      <= '0;
            aux_q      <= '0;
            split_q    <= 1'b0;
            first_pend <= 1'b0;
        end else if (req_acc) begin
            seg_ea     <= ea_aligned;
            seg_len    <= '0;
            tag_q      <= i_req_tag;
            aux_q      <= i_req_aux;
            split_q    <= i_split_en;
            first_pend <= 1'b1;
        end else if (beat_acc) begin
            first_pend <= close;
            if (close) begin
                seg_ea  <= seg_ea + EA_WIDTH'(new_len);
                seg_len <= '0;
            end else begin
                seg_len <= new_len;
            end
        end
    end

    // Single output register for forwarded beats and their command markers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_data_v     <= 1'b0;
            o_data_first <= 1'b0;
            o_data_last  <= 1'b0;
        end else if (beat_acc) begin
            o_data_v     <= 1'b1;
            o_data_first <= first_pend;
            o_data_last  <= close;
        end else if (i_data_r) begin
            o_data_v     <= 1'b0;
            o_data_first <= 1'b0;
            o_data_last  <= 1'b0;
        end
    end

    // Sticky flag for a misaligned start address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              o_err <= 1'b0;
        else if (req_acc && |i_req_ea[BB_W-1:0]) o_err <= 1'b1;
    end

    // Command FIFO pointers; extra MSB tells full from empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Command FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{ea: seg_ea, tsize: new_len, tag: tag_q,
                                           aux: aux_q, last: i_data_e};
    end

    // Head of FIFO, zeroed when empty so idle outputs read as 0
    always_comb begin
        head        = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
        o_cmd_v     = ~fifo_empty;
        o_cmd_ea    = head.ea;
        o_cmd_tsize = head.tsize;
        o_cmd_tag   = head.tag;
        o_cmd_aux   = head.aux;
        o_cmd_final = head.last;
        o_busy      = (state == STREAM) | ~fifo_empty;
    end
endmodule

// File: tb/tb_capi_put_cmd_split.sv
// Directed bench for capi_put_cmd_split (CMD_DEPTH=2 to exercise FIFO-full stall).
module tb_capi_put_cmd_split;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_v, o_req_r;
    logic [63:0] i_req_ea;
    logic [4:0]  i_req_tag;
    logic [23:0] i_req_aux;
    logic        i_split_en;
    logic        i_data_v, o_data_r;
    logic [3:0]  i_data_cnt;
    logic        i_data_e, o_data_v, i_data_r, o_data_first, o_data_last;
    logic        o_cmd_v, i_cmd_r;
    logic [63:0] o_cmd_ea;
    logic [12:0] o_cmd_tsize;
    logic [4:0]  o_cmd_tag;
    logic [23:0] o_cmd_aux;
    logic        o_cmd_final, o_busy, o_err;

    int vectors = 0;
    int errs    = 0;

    logic [63:0] q_ea[$];
    logic [12:0] q_ts[$];
    logic [4:0]  q_tag[$];
    logic [23:0] q_aux[$];
    logic        q_fin[$];
    logic [1:0]  q_beat[$];

    capi_put_cmd_split #(.CMD_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .i_req_v(i_req_v), .o_req_r(o_req_r), .i_req_ea(i_req_ea), .i_req_tag(i_req_tag),
        .i_req_aux(i_req_aux), .i_split_en(i_split_en),
        .i_data_v(i_data_v), .o_data_r(o_data_r), .i_data_cnt(i_data_cnt), .i_data_e(i_data_e),
        .o_data_v(o_data_v), .i_data_r(i_data_r), .o_data_first(o_data_first), .o_data_last(o_data_last),
        .o_cmd_v(o_cmd_v), .i_cmd_r(i_cmd_r), .o_cmd_ea(o_cmd_ea), .o_cmd_tsize(o_cmd_tsize),
        .o_cmd_tag(o_cmd_tag), .o_cmd_aux(o_cmd_aux), .o_cmd_final(o_cmd_final),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Record popped commands and forwarded beats mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            if (o_cmd_v && i_cmd_r) begin
                q_ea.push_back(o_cmd_ea);   q_ts.push_back(o_cmd_tsize);
                q_tag.push_back(o_cmd_tag); q_aux.push_back(o_cmd_aux);
                q_fin.push_back(o_cmd_final);
            end
            if (o_data_v && i_data_r) q_beat.push_back({o_data_first, o_data_last});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_ea.delete(); q_ts.delete(); q_tag.delete(); q_aux.delete(); q_fin.delete(); q_beat.delete();
    endtask

    task automatic req(input logic [63:0] ea, input logic [4:0] tag, input logic sp);
        int t;
        @(posedge clk); #1;
        i_req_v = 1'b1; i_req_ea = ea; i_req_tag = tag; i_req_aux = 24'hA00000 | 24'(tag); i_split_en = sp;
        t = 0;
        @(negedge clk);
        while (!o_req_r && t < 50) begin @(negedge clk); t++; end
        chk("req_timeout", 64'(t < 50), 64'd1);
        @(posedge clk); #1;
        i_req_v = 1'b0;
    endtask

    task automatic beat(input logic [3:0] cnt, input logic e);
        int t;
        i_data_v = 1'b1; i_data_cnt = cnt; i_data_e = e;
        t = 0;
        @(negedge clk);
        while (!o_data_r && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("beat_timeout", 64'(t), 64'd0);
        @(posedge clk); #1;
        i_data_v = 1'b0; i_data_e = 1'b0; i_data_cnt = '0;
    endtask

    task automatic drain();
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; i_req_v = 0; i_req_ea = '0; i_req_tag = '0; i_req_aux = '0; i_split_en = 0;
        i_data_v = 0; i_data_cnt = '0; i_data_e = 0; i_data_r = 1'b1; i_cmd_r = 1'b0;
        repeat (2) @(posedge clk); #1;
        // reset values
        chk("rst_req_r",  o_req_r, 1);   chk("rst_data_r", o_data_r, 0);
        chk("rst_data_v", o_data_v, 0);  chk("rst_cmd_v",  o_cmd_v, 0);
        chk("rst_busy",   o_busy, 0);    chk("rst_err",    o_err, 0);
        reset = 1'b1; i_cmd_r = 1'b1;

        // 1: 0x1000, 8 full beats, no split -> one 128-byte command
        clear_q();
        req(64'h1000, 5'd1, 1'b0);
        for (int i = 0; i < 8; i++) beat(4'd0, i == 7);
        drain();
        chk("t1_ncmd", q_ea.size(), 1);
        chk("t1_ea", q_ea[0], 64'h1000); chk("t1_ts", q_ts[0], 128); chk("t1_fin", q_fin[0], 1);
        chk("t1_tag", q_tag[0], 1);      chk("t1_aux", q_aux[0], 24'hA00001);
        chk("t1_nbeat", q_beat.size(), 8);
        for (int i = 0; i < 8 && i < q_beat.size(); i++)
            chk($sformatf("t1_beat%0d", i), q_beat[i], {1'b0 | (i == 0), 1'b0 | (i == 7)});

        // 2: 0x0FC0 crosses page after 4 beats
        clear_q();
        req(64'h0FC0, 5'd2, 1'b0);
        for (int i = 0; i < 8; i++) beat(4'd0, i == 7);
        drain();
        chk("t2_ncmd", q_ea.size(), 2);
        chk("t2_ea0", q_ea[0], 64'h0FC0); chk("t2_ts0", q_ts[0], 64); chk("t2_fin0", q_fin[0], 0);
        chk("t2_ea1", q_ea[1], 64'h1000); chk("t2_ts1", q_ts[1], 64); chk("t2_fin1", q_fin[1], 1);
        for (int i = 0; i < 8 && i < q_beat.size(); i++)
            chk($sformatf("t2_beat%0d", i), q_beat[i],
                {1'b0 | (i == 0 || i == 4), 1'b0 | (i == 3 || i == 7)});

        // 3: 0x01F0, 40 beats, split at 512
        clear_q();
        req(64'h01F0, 5'd3, 1'b1);
        for (int i = 0; i < 40; i++) beat(4'd0, i == 39);
        drain();
        chk("t3_ncmd", q_ea.size(), 3);
        chk("t3_ea0", q_ea[0], 64'h1F0); chk("t3_ts0", q_ts[0], 16);  chk("t3_fin0", q_fin[0], 0);
        chk("t3_ea1", q_ea[1], 64'h200); chk("t3_ts1", q_ts[1], 512); chk("t3_fin1", q_fin[1], 0);
        chk("t3_ea2", q_ea[2], 64'h400); chk("t3_ts2", q_ts[2], 112); chk("t3_fin2", q_fin[2], 1);
        chk("t3_nbeat", q_beat.size(), 40);
        for (int i = 0; i < 40 && i < q_beat.size(); i++)
            chk($sformatf("t3_beat%0d", i), q_beat[i],
                {1'b0 | (i == 0 || i == 1 || i == 33), 1'b0 | (i == 0 || i == 32 || i == 39)});

        // 4: partial last beat
        clear_q();
        req(64'h2000, 5'd4, 1'b0);
        beat(4'd0, 0); beat(4'd0, 0); beat(4'd4, 1);
        drain();
        chk("t4_ncmd", q_ea.size(), 1);
        chk("t4_ts", q_ts[0], 36); chk("t4_fin", q_fin[0], 1); chk("t4_err", o_err, 0);

        // 5: FIFO full stalls the third beat until a pop
        clear_q();
        i_cmd_r = 1'b0;
        req(64'h3000, 5'd11, 1'b0); beat(4'd0, 1);
        req(64'h3010, 5'd12, 1'b0); beat(4'd0, 1);
        req(64'h3020, 5'd13, 1'b0);
        i_data_v = 1'b1; i_data_cnt = '0; i_data_e = 1'b1;
        repeat (3) begin @(negedge clk); chk("t5_stall", o_data_r, 0); end
        chk("t5_cmd_v", o_cmd_v, 1);
        @(posedge clk); #1; i_cmd_r = 1'b1;
        @(posedge clk); #1; i_cmd_r = 1'b0;
        @(negedge clk); chk("t5_release", o_data_r, 1);
        @(posedge clk); #1; i_data_v = 1'b0; i_data_e = 1'b0;
        i_cmd_r = 1'b1;
        drain();
        chk("t5_ncmd", q_ea.size(), 3);
        chk("t5_ea0", q_ea[0], 64'h3000); chk("t5_tag0", q_tag[0], 11);
        chk("t5_ea1", q_ea[1], 64'h3010); chk("t5_tag1", q_tag[1], 12);
        chk("t5_ea2", q_ea[2], 64'h3020); chk("t5_tag2", q_tag[2], 13);
        chk("t5_ts2", q_ts[2], 16);

        // 6: unaligned address, sticky error, reset mid-stream
        clear_q();
        req(64'h1008, 5'd7, 1'b0);
        chk("t6_err", o_err, 1);
        beat(4'd0, 0); beat(4'd0, 1);
        drain();
        chk("t6_ea", q_ea[0], 64'h1000); chk("t6_ts", q_ts[0], 32);
        i_cmd_r = 1'b0;
        req(64'h4FF0, 5'd8, 1'b0);
        chk("t6_err_sticky", o_err, 1);
        beat(4'd0, 0);
        chk("t6_mid_cmd_v", o_cmd_v, 1);   chk("t6_mid_ea", o_cmd_ea, 64'h4FF0);
        chk("t6_mid_fin", o_cmd_final, 0); chk("t6_mid_busy", o_busy, 1);
        chk("t6_mid_req_r", o_req_r, 0);
        reset = 1'b0; #1;
        chk("t6_rst_req_r", o_req_r, 1); chk("t6_rst_data_v", o_data_v, 0);
        chk("t6_rst_cmd_v", o_cmd_v, 0); chk("t6_rst_cmd_ea", o_cmd_ea, 0);
        chk("t6_rst_busy", o_busy, 0);   chk("t6_rst_err", o_err, 0);
        chk("t6_rst_data_r", o_data_r, 0);
        @(posedge clk); #1; reset = 1'b1; i_cmd_r = 1'b1;

        // 7: after reset, a single partial beat still forms a command
        clear_q();
        req(64'h5000, 5'd9, 1'b0);
        beat(4'd4, 1);
        drain();
        chk("t7_ncmd", q_ea.size(), 1);
        chk("t7_ea", q_ea[0], 64'h5000); chk("t7_ts", q_ts[0], 4); chk("t7_fin", q_fin[0], 1);
        chk("t7_beat", q_beat[0], 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
